// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PID values, packet kinds,
// RXCMD field positions and CRC constants.
package usb_pkg;

   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_SOF   = 8'hA5;
   localparam logic [7:0] PID_SETUP = 8'h2D;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;

   localparam int RXCMD_LS     = 0;
   localparam int RXCMD_ACTIVE = 4;
   localparam int RXCMD_ERR    = 5;

   localparam logic [4:0]  CRC5_POLY    = 5'h14;
   localparam logic [4:0]  CRC5_INIT    = 5'h1F;
   localparam logic [4:0]  CRC5_RESID   = 5'h06;
   localparam logic [15:0] CRC16_POLY   = 16'hA001;
   localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
   localparam logic [15:0] CRC16_RESID  = 16'hB001;

   typedef enum logic [1:0] {
      KIND_TOKEN   = 2'd0,
      KIND_DATA    = 2'd1,
      KIND_HSK     = 2'd2,
      KIND_SPECIAL = 2'd3
   } pkt_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TOKEN,
      ST_DATA,
      ST_HSK,
      ST_SKIP,
      ST_DROP,
      ST_DONE
   } rx_state_e;

   function automatic pkt_kind_e pid_kind(input logic [1:0] t);
      pkt_kind_e k;
      unique case (t)
         2'b01:   k = KIND_TOKEN;
         2'b11:   k = KIND_DATA;
         2'b10:   k = KIND_HSK;
         default: k = KIND_SPECIAL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/ulpi_rx_packetizer_if.sv
// ULPI receive pins plus the packet/payload handshake
// toward the protocol FSM.
interface ulpi_rx_packetizer_if #(
   parameter int LEN_W = 7
);

   logic             ulpi_dir;
   logic             ulpi_nxt;
   logic [7:0]       ulpi_data_in;
   logic [1:0]       linestate;
   logic             rx_active;
   logic             pkt_valid;
   logic             pkt_ack;
   logic [3:0]       pkt_pid;
   logic [1:0]       pkt_kind;
   logic [6:0]       pkt_addr;
   logic [3:0]       pkt_endp;
   logic [LEN_W-1:0] pkt_len;
   logic             pkt_crc_ok;
   logic             pkt_err;
   logic [LEN_W-1:0] rd_addr;
   logic [7:0]       rd_data;
   logic             overrun;

   modport slave (
      input  ulpi_dir,
      input  ulpi_nxt,
      input  ulpi_data_in,
      input  pkt_ack,
      input  rd_addr,
      output linestate,
      output rx_active,
      output pkt_valid,
      output pkt_pid,
      output pkt_kind,
      output pkt_addr,
      output pkt_endp,
      output pkt_len,
      output pkt_crc_ok,
      output pkt_err,
      output rd_data,
      output overrun
   );

   modport master (
      output ulpi_dir,
      output ulpi_nxt,
      output ulpi_data_in,
      output pkt_ack,
      output rd_addr,
      input  linestate,
      input  rx_active,
      input  pkt_valid,
      input  pkt_pid,
      input  pkt_kind,
      input  pkt_addr,
      input  pkt_endp,
      input  pkt_len,
      input  pkt_crc_ok,
      input  pkt_err,
      input  rd_data,
      input  overrun
   );

endinterface

// File: rtl/usb_crc_byte.sv
// One-byte reflected CRC step, LSB first; width and
// polynomial select CRC5 or CRC16.
module usb_crc_byte #(
   parameter int         W    = 16,
   parameter logic [W-1:0] POLY = '0
) (
   input  logic [W-1:0] crc_in,
   input  logic [7:0]   data,
   output logic [W-1:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_out[0] ^ data[i])
            crc_out = (crc_out >> 1) ^ POLY;
         else
            crc_out = crc_out >> 1;
      end
   end

endmodule

// File: rtl/ulpi_rx_packetizer.sv
// ULPI receive framer: splits RXCMD from USB bytes, frames
// packets, checks PID/CRC and buffers the data payload.
module ulpi_rx_packetizer
   import usb_pkg::*;
#(
   parameter int MAX_PAYLOAD = 64,
   parameter int LEN_W       = 7
) (
   input logic                 clk,
   input logic                 RESET,
   ulpi_rx_packetizer_if.slave bus
);

   localparam int AW = $clog2(MAX_PAYLOAD);
   localparam logic [LEN_W-1:0] CNT_MAX = '1;
   localparam logic [LEN_W-1:0] PAY_LIM = LEN_W'(MAX_PAYLOAD);
   localparam logic [LEN_W-1:0] OVF_LIM = LEN_W'(MAX_PAYLOAD + 2);
   localparam logic [LEN_W-1:0] TWO     = LEN_W'(2);

   rx_state_e state;
   rx_state_e state_n;

   logic [7:0]       d;
   logic             dir_q;
   logic             rxcmd;
   logic             usb_byte;
   logic             in_pkt;
   logic             eop;
   logic             busy;
   logic             start;
   logic             publish;
   logic             counting;
   logic             wr_en;

   logic [7:0]       pid_q;
   logic             pid_bad;
   logic             rx_err;
   logic             ovf;
   logic [LEN_W-1:0] cnt;
   logic [6:0]       addr_q;
   logic [3:0]       endp_q;
   logic [4:0]       crc5_q;
   logic [4:0]       crc5_n;
   logic [15:0]      crc16_q;
   logic [15:0]      crc16_n;

   pkt_kind_e        kind_q;
   logic             len_err;
   logic             crc_ok;
   logic [LEN_W-1:0] len_c;

   logic [7:0]       mem [MAX_PAYLOAD];

   assign d        = bus.ulpi_data_in;
   assign rxcmd    = bus.ulpi_dir & dir_q & ~bus.ulpi_nxt;
   assign usb_byte = bus.ulpi_dir & dir_q & bus.ulpi_nxt;
   assign in_pkt   = state inside {ST_TOKEN, ST_DATA, ST_HSK,
                                   ST_SKIP, ST_DROP};
   assign eop      = in_pkt & ((dir_q & ~bus.ulpi_dir) |
                               (rxcmd & ~d[RXCMD_ACTIVE]));
   // an ack in the same cycle frees the slot for the new PID
   assign busy     = bus.pkt_valid & ~bus.pkt_ack;
   assign counting = usb_byte &
                     (state inside {ST_TOKEN, ST_DATA,
                                    ST_HSK, ST_SKIP});
   assign wr_en    = usb_byte & (state == ST_DATA) &
                     (cnt < PAY_LIM);

   usb_crc_byte #(
      .W    (5),
      .POLY (CRC5_POLY)
   ) u_crc5 (
      .crc_in  (crc5_q),
      .data    (d),
      .crc_out (crc5_n)
   );

   usb_crc_byte #(
      .W    (16),
      .POLY (CRC16_POLY)
   ) u_crc16 (
      .crc_in  (crc16_q),
      .data    (d),
      .crc_out (crc16_n)
   );

   always_ff @(posedge clk) begin
      if (!RESET) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      publish = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (usb_byte) begin
               if (busy) begin
                  state_n = ST_DROP;
               end else begin
                  start = 1'b1;
                  unique case (pid_kind(d[1:0]))
                     KIND_TOKEN: state_n = ST_TOKEN;
                     KIND_DATA:  state_n = ST_DATA;
                     KIND_HSK:   state_n = ST_HSK;
                     default:    state_n = ST_SKIP;
                  endcase
               end
            end
         end
         ST_TOKEN, ST_DATA, ST_HSK, ST_SKIP: begin
            if (eop) state_n = ST_DONE;
         end
         ST_DROP: begin
            if (eop) state_n = ST_IDLE;
         end
         ST_DONE: begin
            publish = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RESET) begin
         dir_q   <= 1'b0;
         pid_q   <= '0;
         pid_bad <= 1'b0;
         rx_err  <= 1'b0;
         ovf     <= 1'b0;
         cnt     <= '0;
         addr_q  <= '0;
         endp_q  <= '0;
         crc5_q  <= CRC5_INIT;
         crc16_q <= CRC16_INIT;
      end else begin
         dir_q <= bus.ulpi_dir;
         if (start) begin
            pid_q   <= d;
            pid_bad <= d[7:4] != ~d[3:0];
            rx_err  <= 1'b0;
            ovf     <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            endp_q  <= '0;
            crc5_q  <= CRC5_INIT;
            crc16_q <= CRC16_INIT;
         end else begin
            if (rxcmd && in_pkt && d[RXCMD_ERR] && d[RXCMD_ACTIVE])
               rx_err <= 1'b1;
            if (counting) begin
               if (cnt != CNT_MAX)
                  cnt <= cnt + LEN_W'(1);
               if (state == ST_DATA) begin
                  crc16_q <= crc16_n;
                  if (cnt >= OVF_LIM) ovf <= 1'b1;
               end
               if (state == ST_TOKEN) begin
                  if (cnt < TWO) crc5_q <= crc5_n;
                  if (cnt == '0) begin
                     addr_q    <= d[6:0];
                     endp_q[0] <= d[7];
                  end
                  if (cnt == LEN_W'(1))
                     endp_q[3:1] <= d[2:0];
               end
            end
         end
      end
   end

   assign kind_q = pid_kind(pid_q[1:0]);
   assign len_c  = (kind_q == KIND_DATA && cnt >= TWO) ?
                   cnt - TWO : '0;

   always_comb begin
      len_err = 1'b0;
      crc_ok  = 1'b0;
      unique case (kind_q)
         KIND_TOKEN: begin
            len_err = cnt != TWO;
            crc_ok  = crc5_q == CRC5_RESID;
         end
         KIND_DATA: crc_ok = crc16_q == CRC16_RESID;
         KIND_HSK: begin
            len_err = cnt != '0;
            crc_ok  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RESET) begin
         bus.linestate  <= 2'b01;
         bus.rx_active  <= 1'b0;
         bus.pkt_valid  <= 1'b0;
         bus.pkt_pid    <= '0;
         bus.pkt_kind   <= '0;
         bus.pkt_addr   <= '0;
         bus.pkt_endp   <= '0;
         bus.pkt_len    <= '0;
         bus.pkt_crc_ok <= 1'b0;
         bus.pkt_err    <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         if (rxcmd) begin
            bus.linestate <= d[RXCMD_LS +: 2];
            bus.rx_active <= d[RXCMD_ACTIVE];
         end
         if (state == ST_IDLE && usb_byte && busy)
            bus.overrun <= 1'b1;
         if (bus.pkt_valid && bus.pkt_ack)
            bus.pkt_valid <= 1'b0;
         if (publish) begin
            bus.pkt_valid  <= 1'b1;
            bus.pkt_pid    <= pid_q[3:0];
            bus.pkt_kind   <= kind_q;
            bus.pkt_addr   <= addr_q;
            bus.pkt_endp   <= endp_q;
            bus.pkt_len    <= len_c;
            bus.pkt_crc_ok <= crc_ok;
            bus.pkt_err    <= pid_bad | rx_err | ovf | len_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[cnt[AW-1:0]] <= d;
   end

   always_ff @(posedge clk) begin
      if (!RESET)
         bus.rd_data <= '0;
      else if (bus.rd_addr < PAY_LIM)
         bus.rd_data <= mem[bus.rd_addr[AW-1:0]];
      else
         bus.rd_data <= '0;
   end

endmodule

// File: tb/tb_ulpi_rx_packetizer.sv
// Directed bench for the ULPI receive framer: tokens, data,
// handshakes, RXCMD interleave, overrun, overflow, reset.
module tb_ulpi_rx_packetizer;
   import usb_pkg::*;

   localparam int MAXP = 64;
   localparam int LW   = 7;

   logic clk;
   logic RESET;
   int   total;
   int   bad;
   int   seen;
   logic [7:0] b2;
   logic [7:0] pl[$];

   ulpi_rx_packetizer_if #(.LEN_W(LW)) bus ();

   ulpi_rx_packetizer #(
      .MAX_PAYLOAD (MAXP),
      .LEN_W       (LW)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #8 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic dr, input logic nx, input logic [7:0] x);
      @(negedge clk);
      bus.ulpi_dir     = dr;
      bus.ulpi_nxt     = nx;
      bus.ulpi_data_in = x;
   endtask

   task automatic ubyte(input logic [7:0] x); drv(1'b1, 1'b1, x); endtask
   task automatic rxcmd(input logic [7:0] x); drv(1'b1, 1'b0, x); endtask
   task automatic turn();  drv(1'b1, 1'b0, 8'h00); endtask
   task automatic dfall(); drv(1'b0, 1'b0, 8'h00); endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (bus.pkt_valid === 1'b1) break;
         @(negedge clk);
      end
      check({tag, "_valid"}, bus.pkt_valid, 1);
   endtask

   task automatic do_ack();
      @(negedge clk);
      bus.pkt_ack = 1'b1;
      @(negedge clk);
      bus.pkt_ack = 1'b0;
      check("ack_clr", bus.pkt_valid, 0);
   endtask

   task automatic rd(input string tag, input int a, input logic [7:0] exp);
      @(negedge clk);
      bus.rd_addr = LW'(a);
      @(negedge clk);
      check(tag, bus.rd_data, exp);
   endtask

   function automatic logic [15:0] crc16_m();
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (pl[i])
         for (int b = 0; b < 8; b++)
            c = (c[0] ^ pl[i][b]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      return c;
   endfunction

   function automatic logic [7:0] tok_b2(input logic [6:0] a,
                                         input logic [3:0] e);
      logic [10:0] f;
      logic [4:0]  c;
      f = {e, a};
      c = 5'h1F;
      for (int i = 0; i < 11; i++)
         c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
      return {~c, e[3:1]};
   endfunction

   task automatic send_data(input logic [7:0] pid, input bit bad_crc,
                            input int rx_at, input bit rx_end);
      logic [15:0] c;
      c = crc16_m();
      turn();
      ubyte(pid);
      foreach (pl[i]) begin
         if (i == rx_at) begin
            rxcmd(8'h11);
            ubyte(pl[i]);
            check("mid_ls", bus.linestate, 2'b01);
            check("mid_act", bus.rx_active, 1);
         end else begin
            ubyte(pl[i]);
         end
      end
      ubyte(~c[7:0]);
      ubyte(bad_crc ? (~c[15:8] ^ 8'h01) : ~c[15:8]);
      if (rx_end) rxcmd(8'h01);
      dfall();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.ulpi_dir     = 1'b0;
      bus.ulpi_nxt     = 1'b0;
      bus.ulpi_data_in = 8'h00;
      bus.pkt_ack      = 1'b0;
      bus.rd_addr      = '0;
      RESET            = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", bus.pkt_valid, 0);
      check("rst_ls", bus.linestate, 2'b01);
      check("rst_act", bus.rx_active, 0);
      check("rst_ovr", bus.overrun, 0);
      check("rst_err", bus.pkt_err, 0);
      check("rst_rd", bus.rd_data, 0);
      RESET = 1'b1;

      turn();
      ubyte(PID_SETUP);
      ubyte(8'h00);
      ubyte(8'h10);
      dfall();
      @(negedge clk);
      check("lat1", bus.pkt_valid, 0);
      @(negedge clk);
      check("lat2", bus.pkt_valid, 1);
      check("setup_kind", bus.pkt_kind, 0);
      check("setup_pid", bus.pkt_pid, 4'hD);
      check("setup_addr", bus.pkt_addr, 0);
      check("setup_endp", bus.pkt_endp, 0);
      check("setup_crc", bus.pkt_crc_ok, 1);
      check("setup_err", bus.pkt_err, 0);
      do_ack();

      b2 = tok_b2(7'h05, 4'h3);
      turn();
      ubyte(PID_OUT);
      ubyte(8'h85);
      ubyte(b2);
      dfall();
      wait_valid("out");
      check("out_pid", bus.pkt_pid, 4'h1);
      check("out_addr", bus.pkt_addr, 7'h05);
      check("out_endp", bus.pkt_endp, 4'h3);
      check("out_crc", bus.pkt_crc_ok, 1);
      check("out_err", bus.pkt_err, 0);
      do_ack();

      turn();
      ubyte(PID_OUT);
      ubyte(8'h85);
      ubyte(b2 ^ 8'h80);
      dfall();
      wait_valid("badc5");
      check("badc5_crc", bus.pkt_crc_ok, 0);
      check("badc5_err", bus.pkt_err, 0);
      do_ack();

      turn();
      ubyte(PID_IN);
      ubyte(8'h85);
      dfall();
      wait_valid("short");
      check("short_err", bus.pkt_err, 1);
      do_ack();

      pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      send_data(PID_DATA0, 1'b0, -1, 1'b0);
      wait_valid("d0");
      check("d0_kind", bus.pkt_kind, 1);
      check("d0_pid", bus.pkt_pid, 4'h3);
      check("d0_len", bus.pkt_len, 8);
      check("d0_crc", bus.pkt_crc_ok, 1);
      check("d0_err", bus.pkt_err, 0);
      rd("d0_rd1", 1, 8'h06);
      rd("d0_rd6", 6, 8'h40);
      do_ack();

      send_data(PID_DATA0, 1'b1, -1, 1'b0);
      wait_valid("d0bad");
      check("d0bad_crc", bus.pkt_crc_ok, 0);
      check("d0bad_len", bus.pkt_len, 8);
      do_ack();

      pl = '{8'hAA, 8'h55, 8'h0F};
      send_data(PID_DATA1, 1'b0, 1, 1'b1);
      wait_valid("rxi");
      check("rxi_pid", bus.pkt_pid, 4'hB);
      check("rxi_len", bus.pkt_len, 3);
      check("rxi_crc", bus.pkt_crc_ok, 1);
      check("rxi_act", bus.rx_active, 0);
      check("rxi_ls", bus.linestate, 2'b01);
      rd("rxi_rd1", 1, 8'h55);
      rd("rxi_rd2", 2, 8'h0F);
      do_ack();

      turn();
      ubyte(8'h2E);
      dfall();
      wait_valid("bpid");
      check("bpid_err", bus.pkt_err, 1);
      do_ack();

      turn();
      ubyte(PID_ACK);
      ubyte(8'h00);
      dfall();
      wait_valid("hsk");
      check("hsk_kind", bus.pkt_kind, 2);
      check("hsk_err", bus.pkt_err, 1);
      do_ack();

      pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      send_data(PID_DATA0, 1'b0, -1, 1'b0);
      wait_valid("hold");
      turn();
      ubyte(PID_NAK);
      dfall();
      pl = '{8'h99, 8'h99, 8'h99, 8'h99};
      send_data(PID_DATA1, 1'b0, -1, 1'b0);
      repeat (4) @(negedge clk);
      check("ovr_valid", bus.pkt_valid, 1);
      check("ovr_pid", bus.pkt_pid, 4'h3);
      check("ovr_len", bus.pkt_len, 8);
      check("ovr_flag", bus.overrun, 1);
      rd("ovr_rd1", 1, 8'h06);
      rd("ovr_rd0", 0, 8'h80);

      turn();
      ubyte(PID_ACK);
      bus.pkt_ack = 1'b1;
      dfall();
      bus.pkt_ack = 1'b0;
      wait_valid("same");
      check("same_pid", bus.pkt_pid, 4'h2);
      check("same_err", bus.pkt_err, 0);
      check("same_crc", bus.pkt_crc_ok, 1);
      check("same_ovr", bus.overrun, 1);
      do_ack();

      pl.delete();
      for (int i = 1; i <= MAXP + 3; i++) pl.push_back(8'(i));
      send_data(PID_DATA1, 1'b0, -1, 1'b0);
      wait_valid("ovf");
      check("ovf_err", bus.pkt_err, 1);
      check("ovf_len", bus.pkt_len, MAXP + 3);
      check("ovf_crc", bus.pkt_crc_ok, 1);
      rd("ovf_rd0", 0, 8'h01);
      rd("ovf_rd63", MAXP - 1, 8'(MAXP));
      do_ack();

      turn();
      rxcmd(8'h12);
      ubyte(PID_DATA1);
      check("pre_ls", bus.linestate, 2'b10);
      ubyte(8'h11);
      ubyte(8'h22);
      @(negedge clk);
      RESET = 1'b0;
      bus.ulpi_dir = 1'b0;
      bus.ulpi_nxt = 1'b0;
      repeat (2) @(negedge clk);
      RESET = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.pkt_valid === 1'b1) seen++;
      end
      check("mrst_nopkt", seen, 0);
      check("mrst_ls", bus.linestate, 2'b01);
      check("mrst_act", bus.rx_active, 0);
      check("mrst_ovr", bus.overrun, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
